// File: rtl/hall_call_panel_pkg.sv
// Shared definitions for the hall call panel: per-channel state encoding
// and the default timing limits.
package hall_call_panel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_REQUEST,
        ST_SERVED,
        ST_RELEASE
    } chan_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int ACK_TIMEOUT_DEF     = 64;

endpackage

// File: rtl/hall_call_panel_if.sv
// Hall panel bus: raw buttons and controller status in, call requests,
// lamps and error flags out. The panel itself uses the slave view.
interface hall_call_panel_if #(
    parameter int N_FLOORS = 12
);
    logic [N_FLOORS-1:0] up_btn;
    logic [N_FLOORS-1:0] dn_btn;
    logic [N_FLOORS-1:0] global_up_rqst_status;
    logic [N_FLOORS-1:0] global_dn_rqst_status;
    logic [N_FLOORS-1:0] up_rqst;
    logic [N_FLOORS-1:0] dn_rqst;
    logic [N_FLOORS-1:0] up_lamp;
    logic [N_FLOORS-1:0] dn_lamp;
    logic [N_FLOORS-1:0] ack_err;

    modport master (
        output up_btn, dn_btn, global_up_rqst_status, global_dn_rqst_status,
        input  up_rqst, dn_rqst, up_lamp, dn_lamp, ack_err
    );

    modport slave (
        input  up_btn, dn_btn, global_up_rqst_status, global_dn_rqst_status,
        output up_rqst, dn_rqst, up_lamp, dn_lamp, ack_err
    );
endinterface

// File: rtl/hall_call_channel.sv
// One hall button channel: 2-flop synchronizer, debounce, single request per
// press, acknowledge timeout with a sticky error bit.
module hall_call_channel
    import hall_call_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic status_i,
    output logic rqst_o,
    output logic lamp_o,
    output logic err_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int WT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LIMIT = WT_W'(ACK_TIMEOUT);

    logic [1:0]      sync_q;
    logic            btn_s;
    chan_state_e     state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [WT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            rqst_q, rqst_d;
    logic            lamp_q, lamp_d;
    logic            err_q, err_d;

    assign btn_s = sync_q[1];

    // NOTE: the synchronizer is reset with everything else so a held button
    // after reset has to re-qualify from scratch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            wait_cnt_q <= '0;
            rqst_q     <= 1'b0;
            lamp_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            sync_q     <= {sync_q[0], btn_i};
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rqst_q     <= rqst_d;
            lamp_q     <= lamp_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no branch infers a latch.
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d  = ST_DEBOUNCE;
                    db_cnt_d = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = status_i ? ST_SERVED : ST_REQUEST;
                    wait_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_REQUEST: begin
                if (status_i) begin
                    state_d = ST_SERVED;
                end else if (wait_cnt_q != WT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            ST_SERVED: begin
                if (!status_i) begin
                    state_d = btn_s ? ST_RELEASE : ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so rqst and lamp rise on the
    // same edge that qualifies the press.
    always_comb begin
        rqst_d = (state_d == ST_REQUEST);
        lamp_d = status_i | rqst_d;
        err_d  = err_q | ((state_q == ST_REQUEST) && (wait_cnt_d == WT_LIMIT));
    end

    assign rqst_o = rqst_q;
    assign lamp_o = lamp_q;
    assign err_o  = err_q;

endmodule

// File: rtl/hall_call_panel.sv
// Hall call panel: one channel per existing button; the top floor has no up
// call and the bottom floor no down call.
module hall_call_panel
    import hall_call_panel_pkg::*;
#(
    parameter int N_FLOORS        = 12,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input logic              clk,
    input logic              reset,
    hall_call_panel_if.slave bus
);
    logic [N_FLOORS-1:0] up_rqst_w, up_lamp_w, up_err_w;
    logic [N_FLOORS-1:0] dn_rqst_w, dn_lamp_w, dn_err_w;
    logic                unused_tieoff;

    for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
        if (f < N_FLOORS - 1) begin : g_up
            hall_call_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACK_TIMEOUT    (ACK_TIMEOUT)
            ) u_up (
                .clk     (clk),
                .reset   (reset),
                .btn_i   (bus.up_btn[f]),
                .status_i(bus.global_up_rqst_status[f]),
                .rqst_o  (up_rqst_w[f]),
                .lamp_o  (up_lamp_w[f]),
                .err_o   (up_err_w[f])
            );
        end else begin : g_up_none
            assign up_rqst_w[f] = 1'b0;
            assign up_lamp_w[f] = 1'b0;
            assign up_err_w[f]  = 1'b0;
        end

        if (f > 0) begin : g_dn
            hall_call_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACK_TIMEOUT    (ACK_TIMEOUT)
            ) u_dn (
                .clk     (clk),
                .reset   (reset),
                .btn_i   (bus.dn_btn[f]),
                .status_i(bus.global_dn_rqst_status[f]),
                .rqst_o  (dn_rqst_w[f]),
                .lamp_o  (dn_lamp_w[f]),
                .err_o   (dn_err_w[f])
            );
        end else begin : g_dn_none
            assign dn_rqst_w[f] = 1'b0;
            assign dn_lamp_w[f] = 1'b0;
            assign dn_err_w[f]  = 1'b0;
        end
    end

    // Inputs of the two missing channels are deliberately ignored.
    assign unused_tieoff = ^{bus.up_btn[N_FLOORS-1], bus.global_up_rqst_status[N_FLOORS-1],
                             bus.dn_btn[0], bus.global_dn_rqst_status[0]};

    assign bus.up_rqst = up_rqst_w;
    assign bus.dn_rqst = dn_rqst_w;
    assign bus.up_lamp = up_lamp_w;
    assign bus.dn_lamp = dn_lamp_w;
    assign bus.ack_err = up_err_w | dn_err_w;

endmodule

// File: tb/tb_hall_call_panel.sv
// Bench for hall_call_panel: directed scenarios plus randomized button and
// status traffic, all compared against an event-level model of the panel.
module tb_hall_call_panel;
    localparam int NF = 12;
    localparam int DB = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hall_call_panel_if #(.N_FLOORS(NF)) bus ();

    hall_call_panel #(
        .N_FLOORS       (NF),
        .DEBOUNCE_CYCLES(DB),
        .ACK_TIMEOUT    (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [NF-1:0] up_raw, dn_raw, up_st, dn_st;

    // Model: per channel, a press is counted in samples of the button as seen
    // two edges late; at DB+1 consecutive samples it becomes a call unless the
    // channel is still busy with the previous call.
    int run_len  [2][NF];
    int age      [2][NF];
    bit pending  [2][NF];
    bit served   [2][NF];
    bit held_over[2][NF];
    bit err_flag [2][NF];
    bit m_lamp   [2][NF];
    bit h1       [2][NF];
    bit h2       [2][NF];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit has_channel(input int d, input int f);
        return (d == 0) ? (f != NF - 1) : (f != 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < NF; f++) begin
                run_len[d][f] = 0;  age[d][f] = 0;
                pending[d][f] = 0;  served[d][f] = 0;
                held_over[d][f] = 0; err_flag[d][f] = 0;
                m_lamp[d][f] = 0;   h1[d][f] = 0; h2[d][f] = 0;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < NF; f++) begin
                bit b;
                bit st;
                b  = h2[d][f];
                st = (d == 0) ? up_st[f] : dn_st[f];
                h2[d][f] = h1[d][f];
                h1[d][f] = (d == 0) ? up_raw[f] : dn_raw[f];
                if (!has_channel(d, f)) continue;
                if (pending[d][f]) begin
                    if (st) begin
                        pending[d][f] = 0;
                        served[d][f]  = 1;
                    end else begin
                        if (age[d][f] < TO) age[d][f]++;
                        if (age[d][f] == TO) err_flag[d][f] = 1;
                    end
                end else if (served[d][f]) begin
                    if (!st) begin
                        served[d][f]    = 0;
                        held_over[d][f] = b;
                    end
                end else if (held_over[d][f]) begin
                    if (!b) held_over[d][f] = 0;
                end else begin
                    run_len[d][f] = b ? run_len[d][f] + 1 : 0;
                    if (run_len[d][f] == DB + 1) begin
                        run_len[d][f] = 0;
                        if (st) served[d][f] = 1;
                        else begin
                            pending[d][f] = 1;
                            age[d][f]     = 0;
                        end
                    end
                end
                m_lamp[d][f] = st | pending[d][f];
            end
        end
    endtask

    task automatic compare_all(input string pfx);
        logic [NF-1:0] e_ur, e_dr, e_ul, e_dl, e_er;
        for (int f = 0; f < NF; f++) begin
            e_ur[f] = pending[0][f];
            e_dr[f] = pending[1][f];
            e_ul[f] = m_lamp[0][f];
            e_dl[f] = m_lamp[1][f];
            e_er[f] = err_flag[0][f] | err_flag[1][f];
        end
        check({pfx, "up_rqst"}, 32'(bus.up_rqst), 32'(e_ur));
        check({pfx, "dn_rqst"}, 32'(bus.dn_rqst), 32'(e_dr));
        check({pfx, "up_lamp"}, 32'(bus.up_lamp), 32'(e_ul));
        check({pfx, "dn_lamp"}, 32'(bus.dn_lamp), 32'(e_dl));
        check({pfx, "ack_err"}, 32'(bus.ack_err), 32'(e_er));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        bus.up_btn = up_raw;
        bus.dn_btn = dn_raw;
        bus.global_up_rqst_status = up_st;
        bus.global_dn_rqst_status = dn_st;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all("");
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rst_");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_inputs();
        up_raw = '0; dn_raw = '0; up_st = '0; dn_st = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rise, lrise, seen, rises, prev, drop, st_k, rq, ek, rq_at_err;
        int btn_t[2][NF];
        int st_t [2][NF];

        clear_inputs();
        bus.up_btn = '0; bus.dn_btn = '0;
        bus.global_up_rqst_status = '0; bus.global_dn_rqst_status = '0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all("reset_");
        @(negedge clk);
        reset = 1'b1;

        // Single up press: request and lamp 2+DB+1 edges after the raw input.
        pulse_reset();
        up_raw[3] = 1'b1;
        rise = 0; lrise = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) up_raw[3] = 1'b0;
            step();
            if (rise == 0 && bus.up_rqst[3]) rise = k;
            if (lrise == 0 && bus.up_lamp[3]) lrise = k;
        end
        check("up3_rqst_latency", 32'(rise), 32'(2 + DB + 1));
        check("up3_lamp_latency", 32'(lrise), 32'(2 + DB + 1));

        // Short glitch shorter than the debounce window.
        clear_inputs();
        pulse_reset();
        dn_raw[5] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) dn_raw[5] = 1'b0;
            step();
            seen |= int'(bus.dn_rqst[5] | bus.dn_lamp[5]);
        end
        check("dn5_glitch_ignored", 32'(seen), 32'(0));

        // Long hold with service: one request, drop on the status edge.
        clear_inputs();
        pulse_reset();
        up_raw[2] = 1'b1;
        rises = 0; prev = 0; drop = 0; st_k = 0;
        for (int k = 1; k <= 200; k++) begin
            up_st[2] = (k >= 10 && k < 50);
            if (st_k == 0 && up_st[2]) st_k = k;
            step();
            if (bus.up_rqst[2] && prev == 0) rises++;
            if (prev == 1 && !bus.up_rqst[2] && drop == 0) drop = k;
            prev = int'(bus.up_rqst[2]);
        end
        up_raw[2] = 1'b0;
        repeat (10) step();
        check("up2_single_request", 32'(rises), 32'(1));
        check("up2_rqst_drop_edge", 32'(drop), 32'(st_k));

        // Buttons of the missing channels.
        clear_inputs();
        pulse_reset();
        up_raw[NF-1] = 1'b1; dn_raw[0] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            seen |= int'(bus.up_rqst[NF-1] | bus.dn_rqst[0] | bus.up_lamp[NF-1] | bus.dn_lamp[0]);
        end
        check("edge_channels_absent", 32'(seen), 32'(0));

        // Unanswered call: error after TO edges, request still up, then reset.
        clear_inputs();
        pulse_reset();
        dn_raw[4] = 1'b1;
        rq = 0; ek = 0; rq_at_err = 0;
        for (int k = 1; k <= 90; k++) begin
            if (k == 12) dn_raw[4] = 1'b0;
            step();
            if (rq == 0 && bus.dn_rqst[4]) rq = k;
            if (ek == 0 && bus.ack_err[4]) begin
                ek = k;
                rq_at_err = int'(bus.dn_rqst[4]);
            end
        end
        check("dn4_err_delay", 32'(ek - rq), 32'(TO));
        check("dn4_rqst_at_err", 32'(rq_at_err), 32'(1));
        pulse_reset();

        // Randomized traffic on all buttons and status lines.
        clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < NF; f++) begin
                btn_t[d][f] = $urandom_range(1, 20);
                st_t[d][f]  = $urandom_range(1, 90);
            end
        end
        for (int r = 0; r < 4000; r++) begin
            if (r % 500 == 499) begin
                pulse_reset();
                continue;
            end
            for (int d = 0; d < 2; d++) begin
                for (int f = 0; f < NF; f++) begin
                    if (btn_t[d][f] == 0) begin
                        if (d == 0) begin
                            up_raw[f] = ~up_raw[f];
                            btn_t[d][f] = up_raw[f] ? $urandom_range(1, 12) : $urandom_range(1, 20);
                        end else begin
                            dn_raw[f] = ~dn_raw[f];
                            btn_t[d][f] = dn_raw[f] ? $urandom_range(1, 12) : $urandom_range(1, 20);
                        end
                    end else begin
                        btn_t[d][f]--;
                    end
                    if (st_t[d][f] == 0) begin
                        if (d == 0) begin
                            up_st[f] = ~up_st[f];
                            st_t[d][f] = up_st[f] ? $urandom_range(1, 25) : $urandom_range(1, 90);
                        end else begin
                            dn_st[f] = ~dn_st[f];
                            st_t[d][f] = dn_st[f] ? $urandom_range(1, 25) : $urandom_range(1, 90);
                        end
                    end else begin
                        st_t[d][f]--;
                    end
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hall_call_panel.md
HALL_CALL_PANEL -- requirements
Module: hall_call_panel

Interface
REQ-001 Parameter N_FLOORS, default 12: number of floors served; floor 0 is the lowest.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles that qualify a press; legal range 1..255.
REQ-003 Parameter ACK_TIMEOUT, default 64: cycles a request may wait for status before an error is flagged; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 up_btn  input  N_FLOORS  raw asynchronous hall "up" buttons, 1 = pressed.
REQ-007 dn_btn  input  N_FLOORS  raw asynchronous hall "down" buttons, 1 = pressed.
REQ-008 global_up_rqst_status  input  N_FLOORS  controller's registered up calls (OR of all lifts).
REQ-009 global_dn_rqst_status  input  N_FLOORS  controller's registered down calls (OR of all lifts).
REQ-010 up_rqst  output  N_FLOORS  up call request to controller, level, registered.
REQ-011 dn_rqst  output  N_FLOORS  down call request to controller, level, registered.
REQ-012 up_lamp  output  N_FLOORS  hall up lamp, registered.
REQ-013 dn_lamp  output  N_FLOORS  hall down lamp, registered.
REQ-014 ack_err  output  N_FLOORS  sticky per-floor flag, set when either direction times out.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer before any use.
REQ-016 up channel at floor N_FLOORS-1 and dn channel at floor 0 SHALL not exist; their rqst and lamp bits are tied 0.
REQ-017 Each channel SHALL implement FSM states IDLE, DEBOUNCE, REQUEST, SERVED, RELEASE.
REQ-018 IDLE: synchronized button 1 -> DEBOUNCE with counter cleared.
REQ-019 DEBOUNCE: button 0 on any cycle -> IDLE; counter reaching DEBOUNCE_CYCLES-1 with button 1 -> REQUEST, or -> SERVED if status is already 1 that cycle.
REQ-020 REQUEST: rqst = 1; status 1 -> SERVED and rqst drops on the next edge; wait counter saturates at ACK_TIMEOUT, where ack_err for the floor sets and rqst stays 1.
REQ-021 SERVED: rqst = 0; status 0 -> RELEASE if button still 1, else IDLE.
REQ-022 RELEASE: button 0 -> IDLE; a held button SHALL never generate a second request.
REQ-023 lamp SHALL equal registered (status OR state==REQUEST), so the lamp lights one cycle after qualification and stays lit through service.
REQ-024 A status rise in IDLE or DEBOUNCE (call placed by another source) SHALL light the lamp without changing state.
REQ-025 Latency from first synchronized-high sample to rqst = DEBOUNCE_CYCLES+1 cycles; from raw input, +2 synchronizer cycles.
REQ-026 ack_err SHALL clear only on reset; it is the OR of both channels of its floor.
REQ-027 Counters SHALL be sized $clog2 of their limit plus 1 and SHALL never wrap.

Reset
REQ-028 reset low SHALL immediately force all FSMs to IDLE, clear counters and synchronizers, and drive up_rqst, dn_rqst, up_lamp, dn_lamp, ack_err to 0.
REQ-029 Reset asserted mid-REQUEST SHALL drop rqst without waiting for status; a button still held after reset re-debounces from IDLE.

Structure
REQ-030 The shared package SHALL hold the channel state enum and the DEBOUNCE_CYCLES and ACK_TIMEOUT defaults.
REQ-031 One sub-module, hall_call_channel (sync, FSM, counters, one rqst/lamp/err bit), SHALL be instantiated per existing button; hall_call_panel only generates, ties off, and ORs errors.

Verification
REQ-032 up_btn[3] high 10 cycles, status stays 0 -> up_rqst[3] rises at cycle 7 after input (2+4+1), lamp with it; ack_err stays 0.
REQ-033 dn_btn[5] pulses 2 cycles, DEBOUNCE_CYCLES=4 -> no dn_rqst[5], no lamp.
REQ-034 up_btn[2] held 200 cycles, status[2] high 3 cycles after rqst then low at cycle 50 -> rqst drops 1 cycle after status rise; lamp follows status; exactly one request issued.
REQ-035 up_btn[11] and dn_btn[0] held -> up_rqst[11], dn_rqst[0] stay 0 throughout.
REQ-036 dn_btn[4] qualified, status never rises -> ack_err[4] sets ACK_TIMEOUT=64 cycles after rqst, rqst still 1; reset low then -> all outputs 0 same cycle.
